// File: rtl/meas_window_ctrl.sv
// Measurement window sequencer: waits for lock and a settle interval, gates
// power-of-two accumulation windows, and latches normalised sums with a valid/ack handshake.
module meas_window_ctrl #(
    parameter int MAX_LOG2 = 20,
    parameter int SETTLE_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sym_clk_ena,
    input  logic                     lock,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     single_shot,
    input  logic [4:0]               win_log2,
    input  logic [SETTLE_W-1:0]      settle_syms,
    input  logic [18+MAX_LOG2-1:0]   dv_acc_i,
    input  logic [18+MAX_LOG2-1:0]   dv_acc_q,
    input  logic [36+MAX_LOG2-1:0]   sq_err_i,
    input  logic [36+MAX_LOG2-1:0]   sq_err_q,
    input  logic                     result_ack,
    output logic                     accum_ena,
    output logic                     accum_clear,
    output logic                     busy,
    output logic [17:0]              ref_i,
    output logic [17:0]              ref_q,
    output logic [35:0]              mse_i,
    output logic [35:0]              mse_q,
    output logic                     result_valid,
    output logic                     overrun,
    output logic [7:0]               abort_cnt,
    output logic [15:0]              win_cnt
);

    typedef enum logic [2:0] {IDLE, WAIT_LOCK, SETTLE, ACCUM, DUMP} state_t;

    localparam logic [4:0] MAX_L = 5'(MAX_LOG2);

    state_t                state_q, state_d;
    logic                  single_q, single_d;
    logic [4:0]            log2_q, log2_d;
    logic [SETTLE_W-1:0]   settle_cfg_q, settle_cfg_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [MAX_LOG2:0]     sym_cnt_q, sym_cnt_d;
    logic                  accum_clear_q, accum_clear_d;
    logic [17:0]           ref_i_q, ref_i_d, ref_q_q, ref_q_d;
    logic [35:0]           mse_i_q, mse_i_d, mse_q_q, mse_q_d;
    logic                  result_valid_q, result_valid_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            abort_cnt_q, abort_cnt_d;
    logic [15:0]           win_cnt_q, win_cnt_d;

    logic                  abort, latch;
    logic [MAX_LOG2:0]     win_last;
    logic [18+MAX_LOG2-1:0] dv_sh_i, dv_sh_q;
    logic [36+MAX_LOG2-1:0] sq_sh_i, sq_sh_q;

    // log2_q is already clamped, so the shifted one always fits the counter
    assign win_last = ({{MAX_LOG2{1'b0}}, 1'b1} << log2_q) - 1'b1;
    assign dv_sh_i  = dv_acc_i >> log2_q;
    assign dv_sh_q  = dv_acc_q >> log2_q;
    assign sq_sh_i  = sq_err_i >> log2_q;
    assign sq_sh_q  = sq_err_q >> log2_q;

    always_comb begin
        state_d        = state_q;
        single_d       = single_q;
        log2_d         = log2_q;
        settle_cfg_d   = settle_cfg_q;
        settle_cnt_d   = settle_cnt_q;
        sym_cnt_d      = sym_cnt_q;
        accum_clear_d  = 1'b0;
        ref_i_d        = ref_i_q;
        ref_q_d        = ref_q_q;
        mse_i_d        = mse_i_q;
        mse_q_d        = mse_q_q;
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;
        abort_cnt_d    = abort_cnt_q;
        win_cnt_d      = win_cnt_q;
        abort          = 1'b0;
        latch          = 1'b0;

        if (stop && state_q != IDLE) begin
            state_d       = IDLE;
            accum_clear_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: if (start && !stop) begin
                    single_d      = single_shot;
                    log2_d        = (win_log2 > MAX_L) ? MAX_L : win_log2;
                    settle_cfg_d  = settle_syms;
                    overrun_d     = 1'b0;
                    abort_cnt_d   = '0;
                    win_cnt_d     = '0;
                    accum_clear_d = 1'b1;
                    state_d       = WAIT_LOCK;
                end
                WAIT_LOCK: if (lock) begin
                    settle_cnt_d = settle_cfg_q;
                    state_d      = SETTLE;
                end
                SETTLE: if (!lock) begin
                    abort = 1'b1;
                end else begin
                    if (sym_clk_ena && settle_cnt_q != '0)
                        settle_cnt_d = settle_cnt_q - 1'b1;
                    // leave on the strobe that reaches zero so that strobe is the last one skipped
                    if (settle_cnt_d == '0) begin
                        sym_cnt_d = '0;
                        state_d   = ACCUM;
                    end
                end
                ACCUM: if (!lock) begin
                    abort = 1'b1;
                end else if (sym_clk_ena) begin
                    if (sym_cnt_q == win_last) begin
                        accum_clear_d = 1'b1;
                        state_d       = DUMP;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
                DUMP: if (!lock) begin
                    abort = 1'b1;
                end else begin
                    latch     = 1'b1;
                    sym_cnt_d = '0;
                    state_d   = single_q ? IDLE : ACCUM;
                end
                default: state_d = IDLE;
            endcase
        end

        if (abort) begin
            state_d       = WAIT_LOCK;
            accum_clear_d = 1'b1;
            if (abort_cnt_q != 8'hFF)
                abort_cnt_d = abort_cnt_q + 1'b1;
        end

        if (latch) begin
            ref_i_d        = dv_sh_i[17:0];
            ref_q_d        = dv_sh_q[17:0];
            mse_i_d        = sq_sh_i[35:0];
            mse_q_d        = sq_sh_q[35:0];
            result_valid_d = 1'b1;
            win_cnt_d      = win_cnt_q + 1'b1;
            if (result_valid_q && !result_ack)
                overrun_d = 1'b1;
        end else if (result_ack && result_valid_q) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            single_q       <= 1'b0;
            log2_q         <= '0;
            settle_cfg_q   <= '0;
            settle_cnt_q   <= '0;
            sym_cnt_q      <= '0;
            accum_clear_q  <= 1'b0;
            ref_i_q        <= 18'd1460;
            ref_q_q        <= 18'd1460;
            mse_i_q        <= '0;
            mse_q_q        <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            abort_cnt_q    <= '0;
            win_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            single_q       <= single_d;
            log2_q         <= log2_d;
            settle_cfg_q   <= settle_cfg_d;
            settle_cnt_q   <= settle_cnt_d;
            sym_cnt_q      <= sym_cnt_d;
            accum_clear_q  <= accum_clear_d;
            ref_i_q        <= ref_i_d;
            ref_q_q        <= ref_q_d;
            mse_i_q        <= mse_i_d;
            mse_q_q        <= mse_q_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
            abort_cnt_q    <= abort_cnt_d;
            win_cnt_q      <= win_cnt_d;
        end
    end

    assign accum_ena    = (state_q == ACCUM) && sym_clk_ena;
    assign accum_clear  = accum_clear_q;
    assign busy         = (state_q != IDLE);
    assign ref_i        = ref_i_q;
    assign ref_q        = ref_q_q;
    assign mse_i        = mse_i_q;
    assign mse_q        = mse_q_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;
    assign abort_cnt    = abort_cnt_q;
    assign win_cnt      = win_cnt_q;

endmodule
